// File: rtl/ex_stage_pkg.sv
// ex_stage_pkg
// Shared definitions for the execute stage:
//   - datapath, PC, register-index and flag widths
//   - 5-bit ALU opcode encodings
//   - bit positions inside the condition-flag register
//   - the EX/MEM pipeline register layout
package ex_stage_pkg;

  localparam int DATA_W = 32;
  localparam int PC_W   = 8;
  localparam int REG_W  = 5;
  localparam int FLAG_W = 5;
  localparam int OP_W   = 5;

  // ALU opcodes
  localparam logic [OP_W-1:0] OP_LW_1 = 5'b00000;
  localparam logic [OP_W-1:0] OP_LW_2 = 5'b00001;
  localparam logic [OP_W-1:0] OP_LW_3 = 5'b00010;
  localparam logic [OP_W-1:0] OP_SW_1 = 5'b00011;
  localparam logic [OP_W-1:0] OP_SW_2 = 5'b00100;
  localparam logic [OP_W-1:0] OP_MOV  = 5'b00101;
  localparam logic [OP_W-1:0] OP_ADD  = 5'b00110;
  localparam logic [OP_W-1:0] OP_SUB  = 5'b00111;
  localparam logic [OP_W-1:0] OP_MUL  = 5'b01000;
  localparam logic [OP_W-1:0] OP_DIV  = 5'b01001;
  localparam logic [OP_W-1:0] OP_AND  = 5'b01010;
  localparam logic [OP_W-1:0] OP_OR   = 5'b01011;
  localparam logic [OP_W-1:0] OP_SHL  = 5'b01100;
  localparam logic [OP_W-1:0] OP_SHR  = 5'b01101;
  localparam logic [OP_W-1:0] OP_CMP  = 5'b01110;
  localparam logic [OP_W-1:0] OP_NOT  = 5'b01111;
  localparam logic [OP_W-1:0] OP_JR   = 5'b10000;
  localparam logic [OP_W-1:0] OP_JPC  = 5'b10001;
  localparam logic [OP_W-1:0] OP_BRFL = 5'b10010;
  localparam logic [OP_W-1:0] OP_CALL = 5'b10011;
  localparam logic [OP_W-1:0] OP_RET  = 5'b10100;
  localparam logic [OP_W-1:0] OP_NOP  = 5'b10101;

  // Condition-flag bit positions
  localparam int FLAG_EQ     = 0;  // A == B
  localparam int FLAG_GT     = 1;  // A >  B, signed
  localparam int FLAG_LT     = 2;  // A <  B, signed
  localparam int FLAG_BORROW = 3;  // A <  B, unsigned
  localparam int FLAG_OVF    = 4;  // signed overflow of A - B

  // EX/MEM pipeline register contents
  typedef struct packed {
    logic              memtoreg;
    logic              memwrite;
    logic              memread;
    logic              regwrite;
    logic              branch;
    logic [PC_W-1:0]   target;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] write_data;
    logic [REG_W-1:0]  write_reg;
  } ex_mem_t;

endpackage

// File: rtl/ex_alu.sv
// ex_alu
// Purely combinational ALU and branch unit of the execute stage.
// Ports:
//   a_i          operand A (ReadData1)
//   b_i          operand B (already muxed between ReadData2 and SignExtImm)
//   op_i         5-bit opcode
//   pc_i         PC of the instruction
//   mask_i       low byte of ReadData2: flag mask for BRFL, return target for RET
//   flags_i      registered condition flags
//   result_o     ALU result / memory address
//   target_o     branch/jump target (0 for non-branch ops)
//   taken_cond_o branch condition, before gating with the Branch control
//   new_flags_o  flags computed from A - B
//   flag_we_o    high on CMP, requests a flag-register update
module ex_alu
  import ex_stage_pkg::*;
(
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [OP_W-1:0]   op_i,
  input  logic [PC_W-1:0]   pc_i,
  input  logic [PC_W-1:0]   mask_i,
  input  logic [FLAG_W-1:0] flags_i,
  output logic [DATA_W-1:0] result_o,
  output logic [PC_W-1:0]   target_o,
  output logic              taken_cond_o,
  output logic [FLAG_W-1:0] new_flags_o,
  output logic              flag_we_o
);

  logic [DATA_W-1:0] diff;
  logic [PC_W-1:0]   pc_plus1;

  assign diff     = a_i - b_i;
  assign pc_plus1 = pc_i + PC_W'(1);

  always_comb begin
    new_flags_o              = '0;
    new_flags_o[FLAG_EQ]     = (a_i == b_i);
    new_flags_o[FLAG_GT]     = ($signed(a_i) > $signed(b_i));
    new_flags_o[FLAG_LT]     = ($signed(a_i) < $signed(b_i));
    new_flags_o[FLAG_BORROW] = (a_i < b_i);
    // Overflow when the operands differ in sign and the result's sign
    // differs from A.
    new_flags_o[FLAG_OVF]    = (a_i[DATA_W-1] ^ b_i[DATA_W-1]) &
                               (diff[DATA_W-1] ^ a_i[DATA_W-1]);
  end

  always_comb begin
    // NOTE: every output gets a default before the case so no path through
    // the block leaves a value unassigned, which would infer a latch.
    result_o     = '0;
    target_o     = '0;
    taken_cond_o = 1'b0;
    flag_we_o    = 1'b0;
    case (op_i)
      OP_LW_1:                   result_o = a_i + b_i;
      OP_LW_2, OP_LW_3, OP_SW_1: result_o = b_i;
      OP_SW_2, OP_MOV:           result_o = a_i;
      OP_ADD:                    result_o = a_i + b_i;
      OP_SUB:                    result_o = diff;
      OP_MUL:                    result_o = a_i * b_i;
      OP_DIV:                    result_o = (b_i == '0) ? '0 : a_i / b_i;
      OP_AND:                    result_o = a_i & b_i;
      OP_OR:                     result_o = a_i | b_i;
      OP_SHL:                    result_o = a_i << b_i[4:0];
      OP_SHR:                    result_o = a_i >> b_i[4:0];
      OP_CMP: begin
        result_o  = diff;
        flag_we_o = 1'b1;
      end
      OP_NOT:                    result_o = ~a_i;
      OP_JR: begin
        target_o     = a_i[PC_W-1:0];
        taken_cond_o = 1'b1;
      end
      OP_JPC: begin
        target_o     = pc_i + b_i[PC_W-1:0];
        taken_cond_o = 1'b1;
      end
      OP_BRFL: begin
        target_o     = a_i[PC_W-1:0];
        taken_cond_o = |(flags_i & mask_i[FLAG_W-1:0]);
      end
      OP_CALL: begin
        target_o     = a_i[PC_W-1:0];
        result_o     = DATA_W'(pc_plus1);
        taken_cond_o = 1'b1;
      end
      OP_RET: begin
        target_o     = mask_i;
        taken_cond_o = 1'b1;
      end
      default: ;  // NOP and undefined codes keep the all-zero defaults
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// ex_stage
// Execute stage between the ID/EX and EX/MEM pipeline registers.
// Selects operand B, runs the ALU/branch unit, keeps the CMP condition
// flags and registers every result plus pass-through control into EX/MEM.
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   ID_EX_*                  decoded instruction fields and controls
//   EX_MEM_*Out / RegWrite   registered copies of the ID/EX controls
//   EX_MEM_Branch            branch taken
//   EX_MEM_BranchTarget      target PC
//   EX_MEM_ALUResult         ALU result / memory address
//   EX_MEM_WriteData         store data (ReadData2)
//   EX_MEM_WriteReg          destination register
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              ID_EX_ALUSrc,
  input  logic              ID_EX_RegWrite,
  input  logic              ID_EX_MemtoReg,
  input  logic              ID_EX_MemWrite,
  input  logic              ID_EX_MemRead,
  input  logic              ID_EX_Branch,
  input  logic [OP_W-1:0]   ID_EX_ALUOp,
  input  logic [PC_W-1:0]   ID_EX_PC,
  input  logic [REG_W-1:0]  ID_EX_Rd,
  input  logic [DATA_W-1:0] ID_EX_ReadData1,
  input  logic [DATA_W-1:0] ID_EX_ReadData2,
  input  logic [DATA_W-1:0] ID_EX_SignExtImm,
  output logic              EX_MEM_MemtoRegOut,
  output logic              EX_MEM_MemWriteOut,
  output logic              EX_MEM_MemReadOut,
  output logic              EX_MEM_RegWrite,
  output logic              EX_MEM_Branch,
  output logic [PC_W-1:0]   EX_MEM_BranchTarget,
  output logic [DATA_W-1:0] EX_MEM_ALUResult,
  output logic [DATA_W-1:0] EX_MEM_WriteData,
  output logic [REG_W-1:0]  EX_MEM_WriteReg
);

  logic [DATA_W-1:0] operand_b;
  logic [DATA_W-1:0] alu_result;
  logic [PC_W-1:0]   alu_target;
  logic              taken_cond;
  logic [FLAG_W-1:0] new_flags;
  logic              flag_we;

  logic [FLAG_W-1:0] flags_d, flags_q;
  ex_mem_t           ex_mem_d, ex_mem_q;

  assign operand_b = ID_EX_ALUSrc ? ID_EX_SignExtImm : ID_EX_ReadData2;

  ex_alu u_alu (
    .a_i          (ID_EX_ReadData1),
    .b_i          (operand_b),
    .op_i         (ID_EX_ALUOp),
    .pc_i         (ID_EX_PC),
    .mask_i       (ID_EX_ReadData2[PC_W-1:0]),
    .flags_i      (flags_q),
    .result_o     (alu_result),
    .target_o     (alu_target),
    .taken_cond_o (taken_cond),
    .new_flags_o  (new_flags),
    .flag_we_o    (flag_we)
  );

  always_comb begin
    // BRFL sees flags_q, so a CMP only becomes visible one cycle later.
    flags_d             = flag_we ? new_flags : flags_q;

    ex_mem_d            = '0;
    ex_mem_d.memtoreg   = ID_EX_MemtoReg;
    ex_mem_d.memwrite   = ID_EX_MemWrite;
    ex_mem_d.memread    = ID_EX_MemRead;
    ex_mem_d.regwrite   = ID_EX_RegWrite;
    ex_mem_d.branch     = ID_EX_Branch & taken_cond;
    ex_mem_d.target     = alu_target;
    ex_mem_d.alu_result = alu_result;
    ex_mem_d.write_data = ID_EX_ReadData2;
    ex_mem_d.write_reg  = ID_EX_Rd;
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the values from before the edge, independent of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q  <= '0;
      ex_mem_q <= '0;
    end else begin
      flags_q  <= flags_d;
      ex_mem_q <= ex_mem_d;
    end
  end

  assign EX_MEM_MemtoRegOut  = ex_mem_q.memtoreg;
  assign EX_MEM_MemWriteOut  = ex_mem_q.memwrite;
  assign EX_MEM_MemReadOut   = ex_mem_q.memread;
  assign EX_MEM_RegWrite     = ex_mem_q.regwrite;
  assign EX_MEM_Branch       = ex_mem_q.branch;
  assign EX_MEM_BranchTarget = ex_mem_q.target;
  assign EX_MEM_ALUResult    = ex_mem_q.alu_result;
  assign EX_MEM_WriteData    = ex_mem_q.write_data;
  assign EX_MEM_WriteReg     = ex_mem_q.write_reg;

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage
// Directed self-checking bench for ex_stage. Each step drives one
// instruction, pushes its expected EX/MEM contents to a scoreboard queue,
// then pops and compares after the capturing clock edge.
module tb_ex_stage;
  import ex_stage_pkg::*;

  logic              clk;
  logic              rst;
  logic              id_alusrc, id_regwrite, id_memtoreg, id_memwrite, id_memread, id_branch;
  logic [OP_W-1:0]   id_aluop;
  logic [PC_W-1:0]   id_pc;
  logic [REG_W-1:0]  id_rd;
  logic [DATA_W-1:0] id_rd1, id_rd2, id_imm;
  logic              o_memtoreg, o_memwrite, o_memread, o_regwrite, o_branch;
  logic [PC_W-1:0]   o_target;
  logic [DATA_W-1:0] o_alu, o_wdata;
  logic [REG_W-1:0]  o_wreg;

  typedef struct {
    string             tag;
    logic [DATA_W-1:0] alu;
    logic              chk_alu;
    logic              branch;
    logic [PC_W-1:0]   target;
    logic [DATA_W-1:0] wdata;
    logic [REG_W-1:0]  wreg;
    logic [3:0]        ctrl;  // {memtoreg, memwrite, memread, regwrite}
  } exp_t;

  exp_t sb[$];
  int   total  = 0;
  int   passed = 0;
  int   failed = 0;

  ex_stage dut (
    .clk                 (clk),
    .rst                 (rst),
    .ID_EX_ALUSrc        (id_alusrc),
    .ID_EX_RegWrite      (id_regwrite),
    .ID_EX_MemtoReg      (id_memtoreg),
    .ID_EX_MemWrite      (id_memwrite),
    .ID_EX_MemRead       (id_memread),
    .ID_EX_Branch        (id_branch),
    .ID_EX_ALUOp         (id_aluop),
    .ID_EX_PC            (id_pc),
    .ID_EX_Rd            (id_rd),
    .ID_EX_ReadData1     (id_rd1),
    .ID_EX_ReadData2     (id_rd2),
    .ID_EX_SignExtImm    (id_imm),
    .EX_MEM_MemtoRegOut  (o_memtoreg),
    .EX_MEM_MemWriteOut  (o_memwrite),
    .EX_MEM_MemReadOut   (o_memread),
    .EX_MEM_RegWrite     (o_regwrite),
    .EX_MEM_Branch       (o_branch),
    .EX_MEM_BranchTarget (o_target),
    .EX_MEM_ALUResult    (o_alu),
    .EX_MEM_WriteData    (o_wdata),
    .EX_MEM_WriteReg     (o_wreg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".alu"},    o_alu, '0);
    check({tag, ".branch"}, {31'd0, o_branch}, '0);
    check({tag, ".target"}, {24'd0, o_target}, '0);
    check({tag, ".wdata"},  o_wdata, '0);
    check({tag, ".wreg"},   {27'd0, o_wreg}, '0);
    check({tag, ".ctrl"},   {28'd0, o_memtoreg, o_memwrite, o_memread, o_regwrite}, '0);
  endtask

  // Drive one instruction, record what EX/MEM must hold after the next edge,
  // then pop and compare once that edge has passed.
  task automatic step(input string tag, input logic [OP_W-1:0] op,
                      input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] rd2,
                      input logic [DATA_W-1:0] imm, input logic alusrc,
                      input logic [PC_W-1:0] pc, input logic [REG_W-1:0] rd,
                      input logic br, input logic [3:0] ctrl,
                      input logic [DATA_W-1:0] exp_alu, input logic chk_alu,
                      input logic exp_br, input logic [PC_W-1:0] exp_tgt);
    exp_t e, got;
    id_aluop = op; id_rd1 = a; id_rd2 = rd2; id_imm = imm; id_alusrc = alusrc;
    id_pc = pc; id_rd = rd; id_branch = br;
    {id_memtoreg, id_memwrite, id_memread, id_regwrite} = ctrl;
    e.tag = tag; e.alu = exp_alu; e.chk_alu = chk_alu; e.branch = exp_br;
    e.target = exp_tgt; e.wdata = rd2; e.wreg = rd; e.ctrl = ctrl;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    if (got.chk_alu) check({got.tag, ".alu"}, o_alu, got.alu);
    check({got.tag, ".branch"}, {31'd0, o_branch}, {31'd0, got.branch});
    check({got.tag, ".target"}, {24'd0, o_target}, {24'd0, got.target});
    check({got.tag, ".wdata"},  o_wdata, got.wdata);
    check({got.tag, ".wreg"},   {27'd0, o_wreg}, {27'd0, got.wreg});
    check({got.tag, ".ctrl"},   {28'd0, o_memtoreg, o_memwrite, o_memread, o_regwrite},
          {28'd0, got.ctrl});
  endtask

  initial begin
    // Reset with arbitrary inputs applied
    rst = 1'b1;
    id_aluop = OP_ADD; id_rd1 = 32'h1234_5678; id_rd2 = 32'hDEAD_BEEF;
    id_imm = 32'h0000_00FF; id_alusrc = 1'b0; id_pc = 8'h55; id_rd = 5'd9;
    id_branch = 1'b1;
    {id_memtoreg, id_memwrite, id_memread, id_regwrite} = 4'b1111;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;

    // Memory ops
    step("lw1",  OP_LW_1, 32'd28, 32'd0, 32'd15, 1'b1, 8'd0, 5'd1, 1'b0, 4'b1011, 32'd43, 1'b1, 1'b0, 8'd0);
    step("lw3",  OP_LW_3, 32'd0,  32'd0, 32'd17, 1'b1, 8'd0, 5'd2, 1'b0, 4'b1011, 32'd17, 1'b1, 1'b0, 8'd0);
    step("sw1",  OP_SW_1, 32'd7,  32'd3, 32'd10, 1'b1, 8'd0, 5'd0, 1'b0, 4'b0100, 32'd10, 1'b1, 1'b0, 8'd0);
    step("sw2",  OP_SW_2, 32'd99, 32'd3, 32'd10, 1'b1, 8'd0, 5'd0, 1'b0, 4'b0100, 32'd99, 1'b1, 1'b0, 8'd0);
    step("mov",  OP_MOV,  32'hCAFE_0001, 32'd4, 32'd0, 1'b0, 8'd0, 5'd6, 1'b0, 4'b0001, 32'hCAFE_0001, 1'b1, 1'b0, 8'd0);

    // Arithmetic / logic, A=10 B=5 from ReadData2
    step("add",  OP_ADD, 32'd10, 32'd5, 32'd77, 1'b0, 8'd0, 5'd3, 1'b0, 4'b0001, 32'd15, 1'b1, 1'b0, 8'd0);
    step("sub",  OP_SUB, 32'd10, 32'd5, 32'd77, 1'b0, 8'd0, 5'd3, 1'b0, 4'b0001, 32'd5,  1'b1, 1'b0, 8'd0);
    step("subw", OP_SUB, 32'd5, 32'd10, 32'd0,  1'b0, 8'd0, 5'd3, 1'b0, 4'b0001, 32'hFFFF_FFFB, 1'b1, 1'b0, 8'd0);
    step("mul",  OP_MUL, 32'd10, 32'd5, 32'd0, 1'b0, 8'd0, 5'd4, 1'b0, 4'b0001, 32'd50, 1'b1, 1'b0, 8'd0);
    step("mulw", OP_MUL, 32'h0001_0001, 32'h0001_0000, 32'd0, 1'b0, 8'd0, 5'd4, 1'b0, 4'b0001, 32'h0001_0000, 1'b1, 1'b0, 8'd0);
    step("div",  OP_DIV, 32'd10, 32'd5, 32'd0, 1'b0, 8'd0, 5'd4, 1'b0, 4'b0001, 32'd2,  1'b1, 1'b0, 8'd0);
    step("and",  OP_AND, 32'd10, 32'd5, 32'd0, 1'b0, 8'd0, 5'd5, 1'b0, 4'b0001, 32'd0,  1'b1, 1'b0, 8'd0);
    step("or",   OP_OR,  32'd10, 32'd5, 32'd0, 1'b0, 8'd0, 5'd5, 1'b0, 4'b0001, 32'd15, 1'b1, 1'b0, 8'd0);
    step("shl",  OP_SHL, 32'd15, 32'd3, 32'd0, 1'b0, 8'd0, 5'd7, 1'b0, 4'b0001, 32'd120, 1'b1, 1'b0, 8'd0);
    step("shr",  OP_SHR, 32'd15, 32'd3, 32'd0, 1'b0, 8'd0, 5'd7, 1'b0, 4'b0001, 32'd1,  1'b1, 1'b0, 8'd0);
    step("shr_big", OP_SHR, 32'h8000_0000, 32'h0000_0023, 32'd0, 1'b0, 8'd0, 5'd7, 1'b0, 4'b0001, 32'h1000_0000, 1'b1, 1'b0, 8'd0);
    step("not",  OP_NOT, 32'd0,  32'd0, 32'd0, 1'b0, 8'd0, 5'd8, 1'b0, 4'b0001, 32'hFFFF_FFFF, 1'b1, 1'b0, 8'd0);
    step("div0", OP_DIV, 32'd7,  32'd0, 32'd0, 1'b0, 8'd0, 5'd8, 1'b0, 4'b0001, 32'd0,  1'b1, 1'b0, 8'd0);

    // Flags: CMP equal, then BRFL on EQ (taken) and on LT (not taken)
    step("cmp_eq",    OP_CMP,  32'd15, 32'd15, 32'd0, 1'b0, 8'd0, 5'd0, 1'b0, 4'b0000, 32'd0, 1'b1, 1'b0, 8'd0);
    step("brfl_eq",   OP_BRFL, 32'd20, 32'h01, 32'd0, 1'b0, 8'd0, 5'd0, 1'b1, 4'b0000, 32'd0, 1'b0, 1'b1, 8'd20);
    step("brfl_lt_n", OP_BRFL, 32'd20, 32'h04, 32'd0, 1'b0, 8'd0, 5'd0, 1'b1, 4'b0000, 32'd0, 1'b0, 1'b0, 8'd20);
    step("cmp_lt",    OP_CMP,  32'd3,  32'd5,  32'd0, 1'b0, 8'd0, 5'd0, 1'b0, 4'b0000, 32'hFFFF_FFFE, 1'b1, 1'b0, 8'd0);
    step("brfl_lt",   OP_BRFL, 32'd20, 32'h04, 32'd0, 1'b0, 8'd0, 5'd0, 1'b1, 4'b0000, 32'd0, 1'b0, 1'b1, 8'd20);
    step("brfl_eq_n", OP_BRFL, 32'd20, 32'h01, 32'd0, 1'b0, 8'd0, 5'd0, 1'b1, 4'b0000, 32'd0, 1'b0, 1'b0, 8'd20);

    // Jumps
    step("jr",   OP_JR,   32'd10, 32'd0,  32'd0, 1'b0, 8'd0,   5'd0, 1'b1, 4'b0000, 32'd0,  1'b0, 1'b1, 8'd10);
    step("jpc",  OP_JPC,  32'd0,  32'd0,  32'd8, 1'b1, 8'd16,  5'd0, 1'b1, 4'b0000, 32'd0,  1'b0, 1'b1, 8'd24);
    step("jpcw", OP_JPC,  32'd0,  32'd0,  32'd10, 1'b1, 8'd250, 5'd0, 1'b1, 4'b0000, 32'd0, 1'b0, 1'b1, 8'd4);
    step("call", OP_CALL, 32'd10, 32'd0,  32'd0, 1'b0, 8'd16,  5'd31, 1'b1, 4'b0001, 32'd17, 1'b1, 1'b1, 8'd10);
    step("ret",  OP_RET,  32'd0,  32'd31, 32'd0, 1'b0, 8'd0,   5'd0, 1'b1, 4'b0000, 32'd0,  1'b0, 1'b1, 8'd31);
    step("jr_nb", OP_JR,  32'd10, 32'd0,  32'd0, 1'b0, 8'd0,   5'd0, 1'b0, 4'b0000, 32'd0,  1'b0, 1'b0, 8'd10);

    // Undefined opcode and NOP: all-zero result, flags left alone
    step("undef", 5'b11111, 32'd9, 32'd9, 32'd9, 1'b0, 8'd9, 5'd9, 1'b1, 4'b1010, 32'd0, 1'b1, 1'b0, 8'd0);
    step("nop",   OP_NOP,   32'd9, 32'd4, 32'd9, 1'b0, 8'd9, 5'd9, 1'b1, 4'b0101, 32'd0, 1'b1, 1'b0, 8'd0);
    step("brfl_keep", OP_BRFL, 32'd33, 32'h04, 32'd0, 1'b0, 8'd0, 5'd0, 1'b1, 4'b0000, 32'd0, 1'b0, 1'b1, 8'd33);

    // Signed overflow: 0x7FFFFFFF - 0xFFFFFFFF
    step("cmp_ovf",  OP_CMP,  32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 8'd0, 5'd0, 1'b0, 4'b0000, 32'h8000_0000, 1'b1, 1'b0, 8'd0);
    step("brfl_ovf", OP_BRFL, 32'd40, 32'h10, 32'd0, 1'b0, 8'd0, 5'd0, 1'b1, 4'b0000, 32'd0, 1'b0, 1'b1, 8'd40);
    step("brfl_gt",  OP_BRFL, 32'd41, 32'h02, 32'd0, 1'b0, 8'd0, 5'd0, 1'b1, 4'b0000, 32'd0, 1'b0, 1'b1, 8'd41);
    step("brfl_slt_n", OP_BRFL, 32'd42, 32'h05, 32'd0, 1'b0, 8'd0, 5'd0, 1'b1, 4'b0000, 32'd0, 1'b0, 1'b0, 8'd42);

    // Async reset between CMP and BRFL wipes the flags
    step("cmp_eq2", OP_CMP, 32'd15, 32'd15, 32'd0, 1'b0, 8'd0, 5'd0, 1'b0, 4'b1111, 32'd0, 1'b1, 1'b0, 8'd0);
    #2 rst = 1'b1;
    #1 check_zero("async_rst");
    #1 rst = 1'b0;
    step("brfl_after_rst", OP_BRFL, 32'd20, 32'h01, 32'd0, 1'b0, 8'd0, 5'd0, 1'b1, 4'b0000, 32'd0, 1'b0, 1'b0, 8'd20);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage pipelined processor, between the ID/EX and EX/MEM pipeline registers.
- Selects the ALU operands and runs the 5-bit ALU opcode.
- Computes branch/jump targets and the branch-taken decision, and holds the CMP condition flags.
- Registers all results and pass-through control into the EX/MEM register on the rising clock edge.

Parameters:
- DATA_W, 32, datapath width
- PC_W, 8, program counter / branch target width
- REG_W, 5, register-index width
- FLAG_W, 5, condition-flag register width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- ID_EX_ALUSrc  in  1  operand-B select (1 = SignExtImm, 0 = ReadData2)
- ID_EX_RegWrite  in  1  register-write control
- ID_EX_MemtoReg  in  1  writeback-from-memory control
- ID_EX_MemWrite  in  1  memory-write control
- ID_EX_MemRead  in  1  memory-read control
- ID_EX_Branch  in  1  instruction is a branch/jump
- ID_EX_ALUOp  in  5  operation code
- ID_EX_PC  in  8  PC of the instruction
- ID_EX_Rd  in  5  destination register
- ID_EX_ReadData1  in  32  operand A
- ID_EX_ReadData2  in  32  register operand B, store data, branch mask
- ID_EX_SignExtImm  in  32  sign-extended immediate
- EX_MEM_MemtoRegOut, EX_MEM_MemWriteOut, EX_MEM_MemReadOut, EX_MEM_RegWrite  out  1 each  registered copies of the ID_EX controls
- EX_MEM_Branch  out  1  branch taken
- EX_MEM_BranchTarget  out  8  target PC
- EX_MEM_ALUResult  out  32  ALU result / memory address
- EX_MEM_WriteData  out  32  store data (ReadData2)
- EX_MEM_WriteReg  out  5  registered ID_EX_Rd

Behaviour:
- rst high, asynchronously: every output and the flag register go to 0.
- Latency: one cycle. Combinational compute; all outputs update on the posedge; no stall/flush inputs.
- Operands: A = ReadData1; B = ALUSrc ? SignExtImm : ReadData2.
- Unsigned modulo-2^32 arithmetic.
- For non-branch ops: Branch = 0 and BranchTarget = 0.
- Opcodes (result = ALUResult):
  - 00000 LW_1: A+B
  - 00001 LW_2: B
  - 00010 LW_3: B
  - 00011 SW_1: B
  - 00100 SW_2: A
  - 00101 MOV: A
  - 00110 ADD: A+B
  - 00111 SUB: A-B
  - 01000 MUL: low 32 bits of A*B
  - 01001 DIV: A/B unsigned; B=0 gives 0
  - 01010 AND: A&B
  - 01011 OR: A|B
  - 01100 SHL: A<<B[4:0]
  - 01101 SHR: A>>B[4:0], logical
  - 01110 CMP: A-B; latches flags
  - 01111 NOT: ~A
  - 10000 JR: target A[7:0]; taken = ID_EX_Branch
  - 10001 JPC: target PC+B[7:0], mod 256; taken = ID_EX_Branch
  - 10010 BRFL: target A[7:0]; taken = ID_EX_Branch & |(flags & ReadData2[4:0])
  - 10011 CALL: target A[7:0]; result = {24'b0, PC+1}; taken = ID_EX_Branch
  - 10100 RET: target ReadData2[7:0]; taken = ID_EX_Branch
  - 10101 NOP and all undefined codes: result 0, Branch 0, target 0
- Flags register:
  - Updated only on a CMP cycle, at the posedge.
  - Bits: [0] A==B, [1] A>B signed, [2] A<B signed, [3] A<B unsigned (borrow), [4] signed overflow of A-B.
  - BRFL reads the registered flags, so a CMP in cycle N is visible to a BRFL in cycle N+1 or later.
- WriteData = ReadData2 for every opcode.
- Control bits and Rd pass through unmodified, regardless of opcode.
- Reset asserted mid-stream clears everything immediately. The first edge after release captures the current inputs.

Decomposition:
- Shared package holds:
  - ALU opcode constants (OP_LW_1 … OP_NOP)
  - flag bit indices (FLAG_EQ, FLAG_GT, FLAG_LT, FLAG_BORROW, FLAG_OVF)
  - the width constants
- One combinational sub-module, ex_alu: inputs A, B, op, PC, mask, flags; outputs result, target, taken_cond, new_flags, flag_we.
- The top level holds the operand mux, the flag register and the EX/MEM register.

Test Plan:
- Reset: rst=1 with arbitrary inputs → all outputs 0. After release, LW_1 with A=28, Imm=15, ALUSrc=1, Rd=1, MemRead=MemtoReg=RegWrite=1 → ALUResult=43, WriteReg=00001, controls 1 after one edge.
- Memory ops:
  - LW_3 with Imm=17 → ALUResult 17.
  - SW_1 with Imm=10, ReadData2=3 → ALUResult 10, WriteData 3, MemWriteOut 1.
- Arithmetic/logic with A=10, B=5, ALUSrc=0: ADD 15, SUB 5, MUL 50, DIV 2, AND 0, OR 15. Also:
  - SHL 15,3 → 120
  - SHR 15,3 → 1
  - NOT 0 → 32'hFFFFFFFF
  - DIV 7,0 → 0
- Flags then BRFL:
  - CMP 15,15, then BRFL with A=20, mask 00001, Branch=1 → Branch 1, target 20.
  - Repeat with mask 00100 → Branch 0.
  - CMP 3,5 then mask 00100 → taken.
- Jumps:
  - JR A=10 → target 10.
  - JPC PC=16, Imm=8, ALUSrc=1 → target 24.
  - CALL PC=16, A=10 → target 10, ALUResult 17.
  - RET ReadData2=31 → target 31, all with Branch 1.
  - JR with ID_EX_Branch=0 → Branch 0.
- NOP/undefined opcode 11111 → ALUResult 0, Branch 0, target 0, flags unchanged. Asserting rst between CMP and BRFL clears the flags, so BRFL is not taken.
